// File: rtl/result_reader_pkg.sv
// Shared widths, register-file geometry and FSM encodings for the result reader.
package result_reader_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;

    // Highest register address; a sweep stops here instead of wrapping to 0.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } rr_state_e;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } rr_mode_e;

endpackage

// File: rtl/result_reader_fifo.sv
// Small synchronous FIFO holding {data, address} result entries for the consumer.
// The head entry comes straight from the storage registers, so it is stable while
// nothing is popped. A push into an empty FIFO becomes visible on the next cycle.
module rr_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A pop frees its slot in the same cycle, so a push into a full FIFO is
    // accepted when the head leaves at the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_reader.sv
// Reads register-file results for the consumer: single reads on controller done
// pulses, or a full ascending sweep of all registers on a dump request. One done
// arriving while busy is parked in a pending slot; further ones are counted lost.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rr_clk,
    input  logic              rr_reset,
    input  logic              rr_done,
    input  logic [ADDR_W-1:0] rr_result_addr,
    input  logic              rr_dump,
    output logic [ADDR_W-1:0] rr_ReadAddress,
    input  logic [DATA_W-1:0] rr_read_data,
    output logic [DATA_W-1:0] rr_out_data,
    output logic [ADDR_W-1:0] rr_out_addr,
    output logic              rr_out_valid,
    input  logic              rr_out_ready,
    output logic              rr_busy,
    output logic              rr_overflow
);

    rr_state_e         state_q, state_d;
    rr_mode_e          mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              ovf_q, ovf_d;

    logic              take_pend;
    logic              take_direct;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              can_push;
    logic [DATA_W+ADDR_W-1:0] fifo_head;

    assign fifo_pop = rr_out_valid && rr_out_ready;
    assign can_push = !fifo_full || fifo_pop;

    assign rr_ReadAddress = addr_q;
    assign rr_busy        = (state_q != IDLE);
    assign rr_overflow    = ovf_q;
    assign rr_out_valid   = !fifo_empty;
    assign {rr_out_data, rr_out_addr} = fifo_head;

    // Control registers: FSM state, read mode, current address, pending slot, loss flag.
    always_ff @(posedge rr_clk or negedge rr_reset) begin
        if (!rr_reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_SINGLE;
            addr_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, address sequencing, FIFO push and pending-slot bookkeeping.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        ovf_d       = ovf_q;
        take_pend   = 1'b0;
        take_direct = 1'b0;
        fifo_push   = 1'b0;

        case (state_q)
            IDLE: begin
                // A done wins over a dump; the dump stays asserted and is seen later.
                if (rr_done) begin
                    addr_d  = rr_result_addr;
                    mode_d  = MODE_SINGLE;
                    state_d = ISSUE;
                end else if (rr_dump) begin
                    addr_d  = '0;
                    mode_d  = MODE_SWEEP;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Read data is valid here; hold the address while the FIFO is full.
                if (can_push) begin
                    fifo_push = 1'b1;
                    if (mode_q == MODE_SWEEP && addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ISSUE;
                    end else if (pend_vld_q) begin
                        take_pend  = 1'b1;
                        pend_vld_d = 1'b0;
                        addr_d     = pend_addr_q;
                        mode_d     = MODE_SINGLE;
                        state_d    = ISSUE;
                    end else if (rr_done) begin
                        // A done landing on the finishing edge goes straight to a new read.
                        take_direct = 1'b1;
                        addr_d      = rr_result_addr;
                        mode_d      = MODE_SINGLE;
                        state_d     = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A done while busy parks in the slot; the slot counts as free on its release edge.
        if (rr_done && state_q != IDLE && !take_direct) begin
            if (!pend_vld_q || take_pend) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = rr_result_addr;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    rr_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rr_clk),
        .rst_n     (rr_reset),
        .push      (fifo_push),
        .push_data ({rr_read_data, addr_q}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: cycle table for single/simultaneous reads,
// then hand-written sweep, backpressure, overlap, reset and pending-release sequences.
module tb_result_reader;
    import result_reader_pkg::*;

    logic              tb_clk = 1'b0;
    logic              rr_reset;
    logic              rr_done;
    logic [ADDR_W-1:0] rr_result_addr;
    logic              rr_dump;
    logic [ADDR_W-1:0] rr_ReadAddress;
    logic [DATA_W-1:0] rr_read_data;
    logic [DATA_W-1:0] rr_out_data;
    logic [ADDR_W-1:0] rr_out_addr;
    logic              rr_out_valid;
    logic              rr_out_ready;
    logic              rr_busy;
    logic              rr_overflow;

    logic [DATA_W-1:0] regfile [REG_COUNT];
    logic [DATA_W+ADDR_W-1:0] got_q[$];
    logic [DATA_W+ADDR_W-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic              done;
        logic [ADDR_W-1:0] addr;
        logic              dump;
        logic              ready;
        logic [ADDR_W-1:0] e_ra;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        logic [ADDR_W-1:0] e_oaddr;
        logic              e_busy;
    } vec_t;

    vec_t vecs [10];

    always #5 tb_clk = ~tb_clk;

    result_reader #(.FIFO_DEPTH(4)) dut (
        .rr_clk         (tb_clk),
        .rr_reset       (rr_reset),
        .rr_done        (rr_done),
        .rr_result_addr (rr_result_addr),
        .rr_dump        (rr_dump),
        .rr_ReadAddress (rr_ReadAddress),
        .rr_read_data   (rr_read_data),
        .rr_out_data    (rr_out_data),
        .rr_out_addr    (rr_out_addr),
        .rr_out_valid   (rr_out_valid),
        .rr_out_ready   (rr_out_ready),
        .rr_busy        (rr_busy),
        .rr_overflow    (rr_overflow)
    );

    // Register-file model: synchronous read, data one cycle after the address.
    always @(posedge tb_clk) begin
        rr_read_data <= regfile[rr_ReadAddress];
    end

    // Record every word the consumer accepts (sampled between edges).
    always @(negedge tb_clk) begin
        if (rr_reset === 1'b1 && rr_out_valid === 1'b1 && rr_out_ready === 1'b1) begin
            got_q.push_back({rr_out_addr, rr_out_data});
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (rr_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_in_budget", 64'(rr_busy), 64'd0);
    endtask

    task automatic push_sweep_exp();
        for (int k = 0; k < REG_COUNT; k++) begin
            exp_q.push_back({ADDR_W'(k), DATA_W'(k * 3)});
        end
    endtask

    task automatic compare_queues(input string name);
        int n;
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int k = 0; k < REG_COUNT; k++) begin
            regfile[k] = DATA_W'(k * 3);
        end
        regfile[1] = 32'h0000_0123;

        // done/addr/dump/ready -> read address, valid, data, out addr, busy
        vecs[0] = '{1'b1, 5'd1, 1'b0, 1'b1, 5'd1, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[1] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h123, 5'd1, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 32'd0,   5'd0, 1'b0};
        vecs[4] = '{1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[5] = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 32'd21,  5'd7, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[8] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0,   5'd0, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 32'd0,   5'd0, 1'b1};

        rr_reset       = 1'b0;
        rr_done        = 1'b0;
        rr_result_addr = '0;
        rr_dump        = 1'b0;
        rr_out_ready   = 1'b1;
        tick();
        tick();
        check("rst_ra",    64'(rr_ReadAddress), 64'd0);
        check("rst_valid", 64'(rr_out_valid),   64'd0);
        check("rst_data",  64'(rr_out_data),    64'd0);
        check("rst_busy",  64'(rr_busy),        64'd0);
        check("rst_ovf",   64'(rr_overflow),    64'd0);
        rr_reset = 1'b1;
        tick();

        // Single read, then done+dump together with the dump held afterwards.
        for (int i = 0; i < 10; i++) begin
            rr_done        = vecs[i].done;
            rr_result_addr = vecs[i].addr;
            rr_dump        = vecs[i].dump;
            rr_out_ready   = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_ra", i),    64'(rr_ReadAddress), 64'(vecs[i].e_ra));
            check($sformatf("vec%0d_valid", i), 64'(rr_out_valid),   64'(vecs[i].e_valid));
            check($sformatf("vec%0d_busy", i),  64'(rr_busy),        64'(vecs[i].e_busy));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i),  64'(rr_out_data), 64'(vecs[i].e_data));
                check($sformatf("vec%0d_oaddr", i), 64'(rr_out_addr), 64'(vecs[i].e_oaddr));
            end
        end
        // Register 1 is read again at the next edge by the sweep.
        regfile[1] = DATA_W'(3);
        rr_done = 1'b0;
        rr_dump = 1'b0;
        wait_idle(200);
        repeat (3) tick();
        exp_q.push_back({5'd1, 32'h123});
        exp_q.push_back({5'd7, 32'd21});
        push_sweep_exp();
        compare_queues("table");

        // Clean sweep: busy drops exactly 64 cycles after leaving IDLE, no wrap.
        rr_dump = 1'b1;
        tick();
        rr_dump = 1'b0;
        repeat (63) tick();
        check("sweep_busy_63", 64'(rr_busy), 64'd1);
        tick();
        check("sweep_busy_64", 64'(rr_busy), 64'd0);
        check("sweep_last_ra", 64'(rr_ReadAddress), 64'd31);
        repeat (3) tick();
        push_sweep_exp();
        compare_queues("sweep");

        // Backpressure: four words buffered, stall on address 4, head held.
        rr_out_ready = 1'b0;
        rr_dump = 1'b1;
        tick();
        rr_dump = 1'b0;
        repeat (20) tick();
        check("bp_ra",    64'(rr_ReadAddress), 64'd4);
        check("bp_valid", 64'(rr_out_valid),   64'd1);
        check("bp_busy",  64'(rr_busy),        64'd1);
        repeat (3) tick();
        check("bp_hold_data", 64'(rr_out_data), 64'd0);
        check("bp_hold_addr", 64'(rr_out_addr), 64'd0);
        check("bp_still_ra",  64'(rr_ReadAddress), 64'd4);
        rr_out_ready = 1'b1;
        wait_idle(200);
        repeat (3) tick();
        push_sweep_exp();
        compare_queues("bp");

        // Overlap: dones 2,3,4 mid-sweep; 2 parks, 3 and 4 are lost.
        rr_dump = 1'b1;
        tick();
        rr_dump = 1'b0;
        repeat (10) tick();
        rr_done = 1'b1;
        rr_result_addr = 5'd2;
        tick();
        check("ovl_ovf_after_first", 64'(rr_overflow), 64'd0);
        rr_result_addr = 5'd3;
        tick();
        rr_result_addr = 5'd4;
        tick();
        rr_done = 1'b0;
        check("ovl_ovf_set", 64'(rr_overflow), 64'd1);
        wait_idle(200);
        repeat (3) tick();
        check("ovl_ovf_sticky", 64'(rr_overflow), 64'd1);
        push_sweep_exp();
        exp_q.push_back({5'd2, 32'd6});
        compare_queues("ovl");

        // Reset mid-stall with words buffered: outputs clear before any edge.
        rr_out_ready = 1'b0;
        rr_dump = 1'b1;
        tick();
        rr_dump = 1'b0;
        repeat (10) tick();
        check("mid_valid_pre", 64'(rr_out_valid), 64'd1);
        rr_reset = 1'b0;
        #1;
        check("mid_rst_ra",    64'(rr_ReadAddress), 64'd0);
        check("mid_rst_data",  64'(rr_out_data),    64'd0);
        check("mid_rst_addr",  64'(rr_out_addr),    64'd0);
        check("mid_rst_valid", 64'(rr_out_valid),   64'd0);
        check("mid_rst_busy",  64'(rr_busy),        64'd0);
        check("mid_rst_ovf",   64'(rr_overflow),    64'd0);
        tick();
        rr_reset = 1'b1;
        rr_out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", 64'(rr_out_valid), 64'd0);
        check("post_rst_busy",  64'(rr_busy),      64'd0);
        check("post_rst_words", 64'(got_q.size()), 64'd0);
        got_q.delete();

        // Pending slot released on the same edge a new done arrives: no loss.
        rr_done = 1'b1;
        rr_result_addr = 5'd10;
        tick();
        rr_result_addr = 5'd11;
        tick();
        rr_result_addr = 5'd12;
        tick();
        rr_done = 1'b0;
        check("rel_ovf", 64'(rr_overflow), 64'd0);
        wait_idle(50);
        repeat (3) tick();
        check("rel_ovf_end", 64'(rr_overflow), 64'd0);
        exp_q.push_back({5'd10, 32'd30});
        exp_q.push_back({5'd11, 32'd33});
        exp_q.push_back({5'd12, 32'd36});
        compare_queues("rel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of result entries buffered toward the consumer; power of two, 2..16.
REQ-002 rr_clk  input  1  single clock; all state changes on rising edge.
REQ-003 rr_reset  input  1  reset, asynchronous, active-low; block in reset while 0.
REQ-004 rr_done  input  1  one-cycle pulse from controller: ALU result has been written to register file.
REQ-005 rr_result_addr  input  5  register-file address holding the new result; sampled with rr_done.
REQ-006 rr_dump  input  1  level request to read out all 32 registers in ascending address order.
REQ-007 rr_ReadAddress  output  5  register-file read address driven to datapath.
REQ-008 rr_read_data  input  32  register-file read data; valid one cycle after rr_ReadAddress changes.
REQ-009 rr_out_data  output  32  result word at FIFO head.
REQ-010 rr_out_addr  output  5  register address the head word was read from.
REQ-011 rr_out_valid  output  1  FIFO head valid.
REQ-012 rr_out_ready  input  1  consumer accepts head when high together with rr_out_valid.
REQ-013 rr_busy  output  1  high in any state other than IDLE.
REQ-014 rr_overflow  output  1  sticky: a done request was lost; cleared only by reset.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE; mode flag SINGLE or SWEEP latched on leaving IDLE.
REQ-016 IDLE: rr_done=1 -> latch rr_result_addr, mode SINGLE, go ISSUE; else rr_dump=1 -> address 0, mode SWEEP, go ISSUE.
REQ-017 rr_done and rr_dump both high in IDLE -> done served; dump not latched (requester keeps it asserted).
REQ-018 ISSUE: drive latched address on rr_ReadAddress; unconditionally go CAPTURE next edge.
REQ-019 CAPTURE: rr_ReadAddress held; if FIFO not full, push {rr_read_data, address} at edge; else stall in CAPTURE, no push.
REQ-020 After push: SINGLE -> IDLE (or ISSUE if a done is pending); SWEEP with address<31 -> address+1, go ISSUE; SWEEP with address=31 -> IDLE, no wrap to 0.
REQ-021 rr_done while not IDLE: stored in one-deep pending slot (address + flag); serviced immediately after current SINGLE read, or after SWEEP completes.
REQ-022 rr_done while pending slot full -> request dropped, rr_overflow set to 1.
REQ-023 Pending done in same cycle as slot release -> new done stored, no overflow.
REQ-024 Latency: rr_done sampled at edge E0 -> rr_ReadAddress valid after E0 -> push at E2 -> rr_out_valid=1 after E2 (2 cycles, FIFO empty, not full).
REQ-025 FIFO: registered outputs; push and pop same cycle allowed when full (pop frees slot, push accepted) and when empty (no bypass; data valid next cycle).
REQ-026 rr_out_data/rr_out_addr stable while rr_out_valid=1 and rr_out_ready=0.
REQ-027 SWEEP of 32 registers with rr_out_ready=1 continuously completes in 64 cycles from leaving IDLE.

Reset
REQ-028 rr_reset=0 asynchronously forces: state IDLE, rr_ReadAddress=0, rr_out_data=0, rr_out_addr=0, rr_out_valid=0, rr_busy=0, rr_overflow=0, FIFO empty, pending slot empty.
REQ-029 Reset mid-SWEEP or mid-stall discards all buffered and pending results; first edge after release evaluates IDLE inputs normally.

Structure
REQ-030 Shared package holds ADDR_W=5, DATA_W=32, REG_COUNT=32, and the state encoding IDLE/ISSUE/CAPTURE.
REQ-031 FIFO implemented as one sub-module, rr_fifo, parameterised by width (DATA_W+ADDR_W) and FIFO_DEPTH, providing full/empty flags.

Verification
REQ-032 Single: rr_done with rr_result_addr=1, regfile[1]=0x0000_0123, ready=1 -> rr_ReadAddress=1 after next edge; rr_out_valid with data 0x123, addr 1 exactly 2 edges after done.
REQ-033 Sweep: regfile[k]=k*3, pulse rr_dump, ready=1 -> 32 words addr 0..31 data 0..93 in order, rr_busy low after 64 cycles, no wrap.
REQ-034 Backpressure: ready=0, sweep with FIFO_DEPTH=4 -> 4 words buffered, FSM stalls in CAPTURE with rr_ReadAddress=4; ready=1 -> sweep resumes, no word lost or duplicated.
REQ-035 Overlap: dones at addr 2, 3, 4 on consecutive cycles during a SWEEP -> addr 2 stored pending, 3 and 4 dropped, rr_overflow=1 and stays 1; addr 2 read after sweep ends.
REQ-036 Simultaneous: rr_done(addr 7) and rr_dump high in IDLE -> only addr 7 read first; dump held -> sweep starts after.
REQ-037 Reset: assert rr_reset=0 mid-sweep with FIFO non-empty -> all outputs at reset values immediately, before next clock edge.
